// File: rtl/hdlc_tx_frame_sched_if.sv
// ----------------------------------------------------------------------------
// hdlc_tx_frame_sched_if
//
// Handshake bundle between the HDLC transmit frame scheduler and the blocks it
// sequences: the AXI-Stream-to-FIFO frame reader and the HDLC encoder.
//
// Signals
//   AXISRdReq   scheduler -> reader   one-cycle pulse, start a frame read
//   AXISRdBusy  reader -> scheduler   reader busy
//   AXISRdDone  reader -> scheduler   one-cycle pulse, frame is in the FIFO
//   FIFOAFull   FIFO -> scheduler     TX FIFO almost full
//   TxStart     scheduler -> encoder  one-cycle pulse, start the encoder
//   TxBusy      encoder -> scheduler  encoder busy
//   TxDone      encoder -> scheduler  one-cycle pulse, frame transmitted
//   AbortReq    scheduler -> both     one-cycle pulse, flush after a timeout
//
// Modports
//   master  the scheduler side
//   slave   the reader / encoder side
// ----------------------------------------------------------------------------
interface hdlc_tx_frame_sched_if;
    logic AXISRdReq;
    logic AXISRdBusy;
    logic AXISRdDone;
    logic FIFOAFull;
    logic TxStart;
    logic TxBusy;
    logic TxDone;
    logic AbortReq;

    modport master (
        output AXISRdReq,
        output TxStart,
        output AbortReq,
        input  AXISRdBusy,
        input  AXISRdDone,
        input  FIFOAFull,
        input  TxBusy,
        input  TxDone
    );

    modport slave (
        input  AXISRdReq,
        input  TxStart,
        input  AbortReq,
        output AXISRdBusy,
        output AXISRdDone,
        output FIFOAFull,
        output TxBusy,
        output TxDone
    );
endinterface

// File: rtl/hdlc_tx_frame_sched.sv
// ----------------------------------------------------------------------------
// hdlc_tx_frame_sched
//
// Frame-level sequencer for the HDLC transmit path. For each frame it starts
// the AXI-Stream-to-FIFO reader, waits for the frame to land in the FIFO,
// starts the HDLC encoder, waits for transmission to finish, then holds an
// inter-frame gap. Both wait states are guarded by a watchdog; on expiry an
// AbortReq pulse flushes the reader and encoder and the gap is still taken.
// Completed frames and timeouts are counted in saturating counters.
//
// Parameters
//   GAP_CYCLES      idle cycles held after every frame or abort (0 acts as 1)
//   TIMEOUT_CYCLES  cycles allowed in RD_WAIT / TX_WAIT before abort (>= 2)
//   CNT_WIDTH       width of the statistics counters
//
// Ports
//   Clk           system clock, rising edge
//   Rst           synchronous active-high reset
//   Enable        run enable, only looked at in IDLE
//   FramePending  upstream has a frame available
//   CntClr        synchronous clear of both statistics counters
//   bus           reader / encoder handshake bundle (master side)
//   Busy          high whenever State is not IDLE
//   State         current state encoding
//   FrameCnt      frames completed, saturating
//   TimeoutCnt    timeouts taken, saturating
//
// All outputs are registered.
// ----------------------------------------------------------------------------
module hdlc_tx_frame_sched #(
    parameter int GAP_CYCLES     = 16,
    parameter int TIMEOUT_CYCLES = 1024,
    parameter int CNT_WIDTH      = 16
) (
    input  logic                     Clk,
    input  logic                     Rst,
    input  logic                     Enable,
    input  logic                     FramePending,
    input  logic                     CntClr,
    hdlc_tx_frame_sched_if.master    bus,
    output logic                     Busy,
    output logic [2:0]               State,
    output logic [CNT_WIDTH-1:0]     FrameCnt,
    output logic [CNT_WIDTH-1:0]     TimeoutCnt
);

    localparam int GAP_EFF = (GAP_CYCLES < 1) ? 1 : GAP_CYCLES;
    localparam int TMR_W   = $clog2(TIMEOUT_CYCLES);
    localparam int GAP_W   = (GAP_EFF > 1) ? $clog2(GAP_EFF) : 1;

    // The timer counts 0..TIMEOUT_CYCLES-1 inside a wait state, so a wait
    // state lasts at most TIMEOUT_CYCLES cycles.
    localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(TIMEOUT_CYCLES - 1);
    // The gap counter counts down from GAP_EFF-1 to 0, one GAP cycle each.
    localparam logic [GAP_W-1:0] GAP_LOAD = GAP_W'(GAP_EFF - 1);

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_RD_REQ  = 3'd1,
        ST_RD_WAIT = 3'd2,
        ST_TX_REQ  = 3'd3,
        ST_TX_WAIT = 3'd4,
        ST_GAP     = 3'd5
    } state_t;

    state_t             state_q, state_d;
    logic [TMR_W-1:0]   timer_q, timer_d;
    logic [GAP_W-1:0]   gap_q,   gap_d;

    logic               timeout_hit;
    logic               frame_done;

    logic               rd_req_d, tx_start_d, abort_d, busy_d;
    logic [CNT_WIDTH-1:0] frame_cnt_d, timeout_cnt_d;

    logic               start_ok;
    logic               timer_expired;

    assign start_ok      = Enable && FramePending && !bus.FIFOAFull &&
                           !bus.AXISRdBusy && !bus.TxBusy;
    assign timer_expired = (timer_q == TMR_LAST);

    // ------------------------------------------------------------------
    // State register and all output flops
    // ------------------------------------------------------------------
    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples the pre-edge values, independent of statement order.
    always_ff @(posedge Clk) begin
        if (Rst) begin
            state_q        <= ST_IDLE;
            timer_q        <= '0;
            gap_q          <= '0;
            bus.AXISRdReq  <= 1'b0;
            bus.TxStart    <= 1'b0;
            bus.AbortReq   <= 1'b0;
            Busy           <= 1'b0;
            FrameCnt       <= '0;
            TimeoutCnt     <= '0;
        end else begin
            state_q        <= state_d;
            timer_q        <= timer_d;
            gap_q          <= gap_d;
            bus.AXISRdReq  <= rd_req_d;
            bus.TxStart    <= tx_start_d;
            bus.AbortReq   <= abort_d;
            Busy           <= busy_d;
            FrameCnt       <= frame_cnt_d;
            TimeoutCnt     <= timeout_cnt_d;
        end
    end

    assign State = state_q;

    // ------------------------------------------------------------------
    // Next-state logic, including the watchdog timer and gap counter
    // ------------------------------------------------------------------
    // NOTE: every signal assigned in a combinational block gets a default
    // first; a path that leaves one unassigned would infer a latch.
    always_comb begin
        state_d     = state_q;
        timer_d     = '0;
        gap_d       = gap_q;
        timeout_hit = 1'b0;
        frame_done  = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (start_ok) begin
                    state_d = ST_RD_REQ;
                end
            end

            // AXISRdDone is deliberately not looked at here.
            ST_RD_REQ: begin
                state_d = ST_RD_WAIT;
            end

            // Done is checked before the watchdog, so done wins a tie.
            ST_RD_WAIT: begin
                timer_d = timer_q + 1'b1;
                if (bus.AXISRdDone) begin
                    state_d = ST_TX_REQ;
                end else if (timer_expired) begin
                    state_d     = ST_GAP;
                    gap_d       = GAP_LOAD;
                    timeout_hit = 1'b1;
                end
            end

            ST_TX_REQ: begin
                state_d = ST_TX_WAIT;
            end

            ST_TX_WAIT: begin
                timer_d = timer_q + 1'b1;
                if (bus.TxDone) begin
                    state_d    = ST_GAP;
                    gap_d      = GAP_LOAD;
                    frame_done = 1'b1;
                end else if (timer_expired) begin
                    state_d     = ST_GAP;
                    gap_d       = GAP_LOAD;
                    timeout_hit = 1'b1;
                end
            end

            ST_GAP: begin
                if (gap_q == '0) begin
                    state_d = ST_IDLE;
                end else begin
                    gap_d = gap_q - 1'b1;
                end
            end

            // Encodings 6 and 7 recover to IDLE on the next edge.
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Output logic: next values of the registered outputs
    // ------------------------------------------------------------------
    // Pulses are decoded from the next state so that they are high in the
    // same cycle that State shows RD_REQ / TX_REQ.
    always_comb begin
        rd_req_d      = (state_d == ST_RD_REQ);
        tx_start_d    = (state_d == ST_TX_REQ);
        abort_d       = timeout_hit;
        busy_d        = (state_d != ST_IDLE);
        frame_cnt_d   = FrameCnt;
        timeout_cnt_d = TimeoutCnt;

        // Clear takes priority over a coincident increment.
        if (CntClr) begin
            frame_cnt_d   = '0;
            timeout_cnt_d = '0;
        end else begin
            if (frame_done && !(&FrameCnt)) begin
                frame_cnt_d = FrameCnt + 1'b1;
            end
            if (timeout_hit && !(&TimeoutCnt)) begin
                timeout_cnt_d = TimeoutCnt + 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_hdlc_tx_frame_sched.sv
// ----------------------------------------------------------------------------
// tb_hdlc_tx_frame_sched
//
// Self-checking bench for hdlc_tx_frame_sched. Two instances are built:
//   dut1  GAP_CYCLES=16, TIMEOUT_CYCLES=64, CNT_WIDTH=16
//   dut2  GAP_CYCLES=0 (acts as 1), TIMEOUT_CYCLES=8, CNT_WIDTH=2
// Inputs are shared; 'sel' chooses which instance sees Enable and which one
// is observed. Expected behaviour for a frame is derived from its read and
// transmit latencies as a timeline of event cycles, and compared every cycle.
// ----------------------------------------------------------------------------
module tb_hdlc_tx_frame_sched;

    localparam int T1 = 64;
    localparam int G1 = 16;
    localparam int T2 = 8;
    localparam int G2 = 0;
    localparam int NEVER = 9999;

    logic Clk = 1'b0;
    logic Rst = 1'b1;
    logic en = 1'b0, pend = 1'b0, clr = 1'b0;
    logic rd_busy = 1'b0, rd_done = 1'b0, fifo_af = 1'b0;
    logic tx_busy = 1'b0, tx_done = 1'b0;
    logic sel = 1'b0;

    hdlc_tx_frame_sched_if bus1 ();
    hdlc_tx_frame_sched_if bus2 ();

    assign bus1.AXISRdBusy = rd_busy;
    assign bus1.AXISRdDone = rd_done;
    assign bus1.FIFOAFull  = fifo_af;
    assign bus1.TxBusy     = tx_busy;
    assign bus1.TxDone     = tx_done;
    assign bus2.AXISRdBusy = rd_busy;
    assign bus2.AXISRdDone = rd_done;
    assign bus2.FIFOAFull  = fifo_af;
    assign bus2.TxBusy     = tx_busy;
    assign bus2.TxDone     = tx_done;

    logic        busy1, busy2;
    logic [2:0]  st1, st2;
    logic [15:0] fc1, tc1;
    logic [1:0]  fc2, tc2;

    hdlc_tx_frame_sched #(
        .GAP_CYCLES(G1), .TIMEOUT_CYCLES(T1), .CNT_WIDTH(16)
    ) dut1 (
        .Clk(Clk), .Rst(Rst), .Enable(en & ~sel), .FramePending(pend),
        .CntClr(clr), .bus(bus1), .Busy(busy1), .State(st1),
        .FrameCnt(fc1), .TimeoutCnt(tc1)
    );

    hdlc_tx_frame_sched #(
        .GAP_CYCLES(G2), .TIMEOUT_CYCLES(T2), .CNT_WIDTH(2)
    ) dut2 (
        .Clk(Clk), .Rst(Rst), .Enable(en & sel), .FramePending(pend),
        .CntClr(clr), .bus(bus2), .Busy(busy2), .State(st2),
        .FrameCnt(fc2), .TimeoutCnt(tc2)
    );

    logic [2:0]  o_state;
    logic        o_rdreq, o_txs, o_abort, o_busy;
    logic [15:0] o_fc, o_tc;

    assign o_state = sel ? st2 : st1;
    assign o_rdreq = sel ? bus2.AXISRdReq : bus1.AXISRdReq;
    assign o_txs   = sel ? bus2.TxStart   : bus1.TxStart;
    assign o_abort = sel ? bus2.AbortReq  : bus1.AbortReq;
    assign o_busy  = sel ? busy2 : busy1;
    assign o_fc    = sel ? {14'd0, fc2} : fc1;
    assign o_tc    = sel ? {14'd0, tc2} : tc1;

    always #5 Clk = ~Clk;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;
    int m_fc   = 0;   // model frame counter
    int m_tc   = 0;   // model timeout counter

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge Clk);
        #1;
        cyc++;
    endtask

    function automatic int sat_inc(input int v);
        int cmax;
        cmax = sel ? 3 : 65535;
        return (v >= cmax) ? cmax : v + 1;
    endfunction

    task automatic set_go();
        Rst = 1'b0; en = 1'b1; pend = 1'b1; fifo_af = 1'b0;
        rd_busy = 1'b0; tx_busy = 1'b0; rd_done = 1'b0; tx_done = 1'b0; clr = 1'b0;
    endtask

    // One frame, starting with the selected DUT in IDLE and the start
    // condition presented for the coming edge. rlat/tlat are the cycles from
    // the AXISRdReq / TxStart cycle to the done pulse. rst_at / clr_at (0 =
    // unused) assert Rst / CntClr in that frame cycle. junk scrambles the
    // inputs that must be ignored outside IDLE.
    task automatic run_frame(input int rlat, input int tlat, input int rst_at,
                             input int clr_at, input bit junk, output int rq_cyc);
        int tmo, geff, rd_last, txs, tx_last, g0, fin, last;
        int es, e_rq, e_ts, e_ab, e_busy;
        bit rd_ok, tx_ok;
        tmo     = sel ? T2 : T1;
        geff    = sel ? ((G2 < 1) ? 1 : G2) : ((G1 < 1) ? 1 : G1);
        rd_ok   = (rlat >= 1) && (rlat <= tmo);
        rd_last = rd_ok ? 1 + rlat : 1 + tmo;
        txs     = rd_last + 1;
        tx_ok   = rd_ok && (tlat >= 1) && (tlat <= tmo);
        tx_last = tx_ok ? txs + tlat : txs + tmo;
        g0      = rd_ok ? tx_last + 1 : rd_last + 1;
        fin     = g0 + geff;
        last    = (rst_at > 0) ? rst_at + 1 : fin;
        rq_cyc  = 0;
        for (int k = 1; k <= last; k++) begin
            tick();
            if (k == 1) rq_cyc = cyc;
            if (rst_at > 0 && k == rst_at + 1) begin
                es = 0; e_rq = 0; e_ts = 0; e_ab = 0; e_busy = 0;
            end else begin
                if (k == 1)                     es = 1;
                else if (k <= rd_last)          es = 2;
                else if (rd_ok && k == txs)     es = 3;
                else if (rd_ok && k <= tx_last) es = 4;
                else if (k < fin)               es = 5;
                else                            es = 0;
                e_rq   = (k == 1);
                e_ts   = (rd_ok && k == txs);
                e_ab   = (!tx_ok && k == g0);
                e_busy = (k < fin);
            end
            check($sformatf("state k=%0d", k),      o_state, es);
            check($sformatf("rdreq k=%0d", k),      o_rdreq, e_rq);
            check($sformatf("txstart k=%0d", k),    o_txs,   e_ts);
            check($sformatf("abort k=%0d", k),      o_abort, e_ab);
            check($sformatf("busy k=%0d", k),       o_busy,  e_busy);
            check($sformatf("framecnt k=%0d", k),   o_fc,    m_fc);
            check($sformatf("timeoutcnt k=%0d", k), o_tc,    m_tc);
            if (k == last) break;

            rd_done = (k == 1 + rlat);
            tx_done = rd_ok && (k == txs + tlat);
            clr     = (k == clr_at);
            Rst     = (k == rst_at);
            if (junk) begin
                en      = 1'($urandom_range(0, 1));
                pend    = 1'($urandom_range(0, 1));
                fifo_af = 1'($urandom_range(0, 1));
                rd_busy = 1'($urandom_range(0, 1));
                tx_busy = 1'($urandom_range(0, 1));
            end

            if (Rst) begin
                m_fc = 0; m_tc = 0;
            end else if (clr) begin
                m_fc = 0; m_tc = 0;
            end else if (k == g0 - 1) begin
                if (tx_ok) m_fc = sat_inc(m_fc);
                else       m_tc = sat_inc(m_tc);
            end
        end
        rd_done = 1'b0; tx_done = 1'b0; clr = 1'b0; Rst = 1'b0;
    endtask

    task automatic hold_idle(input string tag, input int n);
        for (int i = 0; i < n; i++) begin
            tick();
            check(tag, o_state, 0);
            check({tag, "_rdreq"}, o_rdreq, 0);
        end
    endtask

    initial begin
        int rq [3];
        int rl [3];
        int tl [3];
        int dummy;

        // Reset state of both instances
        Rst = 1'b1;
        tick(); tick();
        check("rst_state",   o_state, 0);
        check("rst_rdreq",   o_rdreq, 0);
        check("rst_txstart", o_txs,   0);
        check("rst_abort",   o_abort, 0);
        check("rst_busy",    o_busy,  0);
        check("rst_fc",      o_fc,    0);
        check("rst_tc",      o_tc,    0);
        check("rst_state2",  st2,     0);
        check("rst_fc2",     fc2,     0);
        Rst = 1'b0;
        hold_idle("idle_disabled", 3);

        // Gating: each blocker alone keeps the scheduler in IDLE
        set_go(); fifo_af = 1'b1;
        hold_idle("gate_fifo", 5);
        set_go(); tx_busy = 1'b1;
        hold_idle("gate_txbusy", 5);
        set_go(); rd_busy = 1'b1;
        hold_idle("gate_rdbusy", 5);
        set_go(); en = 1'b0;
        hold_idle("gate_enable", 5);
        set_go(); pend = 1'b0;
        hold_idle("gate_pending", 5);
        set_go(); fifo_af = 1'b1;
        hold_idle("gate_fifo2", 3);

        // Dropping FIFOAFull starts the nominal frame on the next cycle
        set_go();
        run_frame(20, 50, 0, 0, 1'b0, dummy);
        check("nominal_fc", o_fc, 1);

        // Back-to-back frames with FramePending held high
        for (int i = 0; i < 3; i++) begin
            rl[i] = (i == 0) ? 20 : int'($urandom_range(1, T1));
            tl[i] = (i == 0) ? 50 : int'($urandom_range(1, T1));
            set_go();
            run_frame(rl[i], tl[i], 0, 0, 1'b0, rq[i]);
        end
        for (int i = 1; i < 3; i++) begin
            check($sformatf("b2b_spacing%0d", i), rq[i] - rq[i-1],
                  rl[i-1] + tl[i-1] + G1 + 3);
        end
        check("b2b_fc", o_fc, 4);

        // Read timeout, then done arriving in RD_REQ (ignored, times out too)
        set_go(); run_frame(NEVER, 0, 0, 0, 1'b0, dummy);
        check("rd_timeout_tc", o_tc, 1);
        set_go(); run_frame(0, 0, 0, 0, 1'b0, dummy);
        // Transmit timeout, and TxDone during TX_REQ (ignored)
        set_go(); run_frame(5, NEVER, 0, 0, 1'b0, dummy);
        set_go(); run_frame(7, 0, 0, 0, 1'b0, dummy);

        // Done on the exact timeout edge wins, in both wait states
        set_go(); run_frame(T1, 10, 0, 0, 1'b0, dummy);
        set_go(); run_frame(5, T1, 0, 0, 1'b0, dummy);

        // CntClr coincident with TxDone: cycle 1+10+1+30
        set_go(); run_frame(10, 30, 0, 42, 1'b0, dummy);
        check("clr_fc", o_fc, 0);
        check("clr_tc", o_tc, 0);

        // Randomised frames with scrambled don't-care inputs
        for (int i = 0; i < 6; i++) begin
            set_go();
            run_frame(int'($urandom_range(0, T1 + 3)), int'($urandom_range(0, T1 + 3)),
                      0, 0, 1'b1, dummy);
        end

        // Reset while in TX_WAIT: all zero next cycle, no abort
        set_go(); run_frame(10, 40, 20, 0, 1'b0, dummy);
        en = 1'b0; pend = 1'b0;
        hold_idle("post_rst", 2);

        // Saturation on the 2-bit instance, zero gap acting as one cycle
        sel = 1'b1; m_fc = 0; m_tc = 0;
        hold_idle("dut2_idle", 2);
        for (int i = 0; i < 5; i++) begin
            set_go();
            run_frame(int'($urandom_range(1, T2)), int'($urandom_range(1, T2)),
                      0, 0, 1'b0, dummy);
        end
        check("sat_fc", o_fc, 3);
        for (int i = 0; i < 4; i++) begin
            set_go();
            run_frame(NEVER, 0, 0, 0, 1'b0, dummy);
        end
        check("sat_tc", o_tc, 3);
        en = 1'b0; pend = 1'b0;
        hold_idle("dut2_end", 2);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/hdlc_tx_frame_sched.md
Name: hdlc_tx_frame_sched

Overview:
- Frame-level sequencer for the HDLC transmit path. It starts the AXI-Stream-to-FIFO frame reader, then hands the buffered frame to the HDLC encoder, then enforces an inter-frame gap.
- Sits between the AXIS reader (AXISRdReq/AXISRdBusy/AXISRdDone handshake) and the encoder start/done handshake.
- Adds watchdog timeouts, abort signalling and frame/error statistics.

Parameters:
- GAP_CYCLES, 16: idle cycles held in GAP after every frame or abort. A value of 0 is treated as 1.
- TIMEOUT_CYCLES, 1024: maximum cycles spent in RD_WAIT or TX_WAIT before abort. Must be at least 2.
- CNT_WIDTH, 16: width of the statistics counters.

Ports:
- Clk  in  1  system clock; all logic is on the rising edge.
- Rst  in  1  reset. One clock; reset is synchronous and active-high.
- Enable  in  1  run enable; sampled only in IDLE.
- FramePending  in  1  upstream has a frame available (level).
- CntClr  in  1  synchronous clear of the statistics counters.
- AXISRdReq  out  1  one-cycle pulse that starts a frame read.
- AXISRdBusy  in  1  reader busy.
- AXISRdDone  in  1  one-cycle pulse: frame fully written to the FIFO.
- FIFOAFull  in  1  TX FIFO almost full.
- TxStart  out  1  one-cycle pulse that starts the encoder.
- TxBusy  in  1  encoder busy.
- TxDone  in  1  one-cycle pulse: frame transmitted.
- AbortReq  out  1  one-cycle pulse on timeout; the reader and encoder flush.
- Busy  out  1  high whenever State is not IDLE.
- State  out  3  current state encoding.
- FrameCnt  out  CNT_WIDTH  frames completed; saturating.
- TimeoutCnt  out  CNT_WIDTH  timeouts taken; saturating.

Behaviour:
- All outputs are registered. On Rst, State=IDLE(0) and every output is 0, including both counters and the timer.
- State encoding: IDLE=0, RD_REQ=1, RD_WAIT=2, TX_REQ=3, TX_WAIT=4, GAP=5. Encodings 6 and 7 are illegal and go to IDLE on the next edge.
- IDLE:
  - Leaves only when Enable & FramePending & !FIFOAFull & !AXISRdBusy & !TxBusy, all sampled on the same edge.
  - On that edge the next state is RD_REQ, so AXISRdReq is high in the following cycle (1-cycle latency).
- RD_REQ:
  - AXISRdReq=1 for exactly this cycle.
  - Timer cleared to 0; next state RD_WAIT unconditionally.
  - AXISRdDone is ignored in RD_REQ.
- RD_WAIT:
  - Timer increments each cycle.
  - AXISRdDone → TX_REQ.
  - Otherwise, timer==TIMEOUT_CYCLES-1 → AbortReq pulse next cycle, TimeoutCnt+1, go to GAP.
  - If done and timeout occur on the same edge, done wins.
- TX_REQ:
  - TxStart=1 for exactly this cycle.
  - Timer cleared; next state TX_WAIT.
- TX_WAIT:
  - TxDone → FrameCnt+1, go to GAP.
  - Timeout → AbortReq, TimeoutCnt+1, go to GAP, with the same rule and priority as RD_WAIT.
  - TxDone in any other state is ignored.
- GAP:
  - Gap counter loads on entry.
  - Stay max(GAP_CYCLES,1) cycles, then IDLE.
  - Enable and FramePending are not sampled in GAP.
- Enable low mid-frame: the frame in flight completes normally. Enable is only checked in IDLE.
- FIFOAFull rising after RD_REQ has no effect on the frame in flight; back-pressure is the reader's concern.
- Counters:
  - Saturate at all-ones with no wrap.
  - CntClr clears both counters; clear beats a simultaneous increment.
  - Rst beats CntClr.
- Rst asserted mid-frame returns to IDLE with no AbortReq pulse; downstream blocks share the same Rst.
- At most one AXISRdReq per frame. A new AXISRdReq is never issued before the previous frame reaches GAP.

Test Plan:
- Nominal frame. Stimulus: Enable=1, FramePending=1, AXISRdDone 20 cycles after AXISRdReq, TxDone 50 cycles after TxStart, GAP_CYCLES=16. Required: one AXISRdReq pulse 1 cycle after the condition; TxStart 1 cycle after AXISRdDone; FrameCnt=1; exactly 16 GAP cycles; back to IDLE.
- Back-to-back frames. Stimulus: FramePending held high for 3 frames. Required: FrameCnt=3; AXISRdReq pulses spaced exactly by read time + tx time + 16 + 3 fixed state cycles.
- Read timeout. Stimulus: TIMEOUT_CYCLES=64, AXISRdDone never pulses. Required: AbortReq pulse 64 cycles after entering RD_WAIT; TimeoutCnt=1; FrameCnt=0; no TxStart; recovery to IDLE after the gap.
- Gating. Stimulus: FIFOAFull=1 or TxBusy=1 while FramePending=1. Required: stays in IDLE with no AXISRdReq. Deasserting FIFOAFull gives AXISRdReq exactly 1 cycle later.
- Simultaneity and clears. Stimulus: AXISRdDone on the exact timeout edge. Required: TX_REQ taken, no AbortReq. Stimulus: CntClr coincident with TxDone. Required: FrameCnt=0.
- Mid-operation reset and saturation. Stimulus: Rst in TX_WAIT. Required: all outputs 0 next cycle, no AbortReq. Stimulus: CNT_WIDTH=2 with 5 frames. Required: FrameCnt=3.
